alu_rs_scheduler: RTL and testbench
===================================

# alu_rs_scheduler

Reservation-station scheduler for the integer ALU of the out-of-order core. Holds up to `RS_SIZE` issued ALU instructions, wakes their operands from the common data bus (CDB), selects one ready entry per cycle, and drives it into the combinational AL_Executor. It registers the executor result and broadcasts it with its ROB tag. It sits between the decoder/issue stage and the CDB arbiter.

## Interface
- `RS_SIZE`, 8: number of entries (power of two, 2..16)
- `TAG_WIDTH`, 4: ROB tag width
- `clk` in 1: clock, all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: misprediction rollback, synchronous
- `issue_valid` in 1: issue request this cycle
- `issue_openum` in 6: ALU operation enum
- `issue_v1`, `issue_v2` in 32: operand values
- `issue_q1_busy`, `issue_q2_busy` in 1: operand still pending
- `issue_q1`, `issue_q2` in TAG_WIDTH: producer tags when pending
- `issue_dest` in TAG_WIDTH: ROB tag of this instruction
- `rs_full` out 1: all entries busy; issue is ignored
- `cdb_valid` in 1, `cdb_tag` in TAG_WIDTH, `cdb_value` in 32: wakeup bus
- `alu_openum` out 6, `alu_oprand1` out 32, `alu_oprand2` out 32: to AL_Executor
- `alu_result` in 32: from AL_Executor, combinational
- `out_valid` out 1, `out_tag` out TAG_WIDTH, `out_value` out 32: registered result broadcast

## Operation
- Entry fields: busy, openum, v1, v2, q1_busy, q2_busy, q1, q2, dest.
- Entry is ready when busy && !q1_busy && !q2_busy.
- `rs_full` = all busy bits set; it is combinational from registered state.
- Issue accept: issue_valid && !rs_full && !flush. The request writes the lowest-index free entry.
- Issue forwarding: if an operand is pending and cdb_valid && cdb_tag == its q, the entry stores cdb_value and clears q*_busy at the same edge.
- Wakeup: at every edge, each busy entry with q*_busy && q* == cdb_tag && cdb_valid captures cdb_value and clears that busy bit. Both operands may wake in the same edge.
- Select: lowest-index ready entry, based on registered state. `alu_*` is driven from the selected entry. The entry's busy bit clears at that edge.
- With no ready entry, `alu_*` is driven to zero and nothing is dispatched.
- Result: at the dispatch edge, out_valid<=1, out_tag<=dest, out_value<=alu_result. With no dispatch, out_valid<=0.
- A freed entry is reusable by issue at the same edge. Freeing never lowers the current-cycle `rs_full`.
- Flush: at the next edge all busy bits <=0 and out_valid<=0. Flush has priority over issue, wakeup and dispatch.
- Reset (async): all busy <=0, out_valid=0, out_tag=0, out_value=0. Reset therefore holds alu_* at 0 and rs_full=0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Operands are 32-bit two's-complement, passed unmodified. No width conversion happens in this block.

## Timing
- Issue with both operands ready at edge t, entry idle otherwise:
  - selectable in cycle t..t+1
  - dispatched at edge t+1
  - out_valid high in cycle t+1..t+2
  - minimum latency 2 edges
- CDB wakeup at edge t: the entry is selectable in the following cycle, with the same 1-edge select latency.
- Throughput: one dispatch per cycle. out_valid may stay high on consecutive cycles.
- Own broadcast looped back through the CDB wakes dependants one edge after out_valid.

## Test plan
- Issue openum=22, v1=1, v2=32'hFFFFFFFF, dest=3, both ready -> two edges later out_valid=1, out_tag=3, out_value equals AL_Executor result for those inputs; out_valid low the cycle after.
- Issue dest=5 with q1_busy=1, q1=2 -> no dispatch. Then cdb_valid=1, cdb_tag=2, cdb_value=7 -> next cycle alu_oprand1=7, then out_tag=5.
- Issue with q2=4 in the same cycle as cdb_tag=4, value=9 -> entry stored ready with v2=9; dispatched next edge.
- Fill all 8 entries with blocked operands -> rs_full=1 and a ninth issue is ignored. Wake entry 6 -> entry 6 dispatches, rs_full drops, and the next issue lands in slot 6.
- Two ready entries at indices 1 and 4 -> index 1 dispatches first and index 4 next cycle, giving out_valid on two consecutive cycles.
- flush asserted with 3 busy entries and an issue pending -> next cycle rs_full=0, no entries, out_valid=0. Assert rst_n=0 mid-cycle -> outputs zero immediately.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds issued ops, wakes operands from the CDB,
// selects the lowest ready entry into the AL_Executor, registers its result.
//   issue_*  : new op from issue stage   rs_full : no free entry
//   cdb_*    : wakeup bus                alu_*   : selected op to executor
//   alu_result : executor result         out_*   : registered broadcast
module alu_rs_scheduler #(
  parameter int RS_SIZE   = 8,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [5:0]           issue_openum,
  input  logic [31:0]          issue_v1,
  input  logic [31:0]          issue_v2,
  input  logic                 issue_q1_busy,
  input  logic                 issue_q2_busy,
  input  logic [TAG_WIDTH-1:0] issue_q1,
  input  logic [TAG_WIDTH-1:0] issue_q2,
  input  logic [TAG_WIDTH-1:0] issue_dest,
  output logic                 rs_full,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  output logic [5:0]           alu_openum,
  output logic [31:0]          alu_oprand1,
  output logic [31:0]          alu_oprand2,
  input  logic [31:0]          alu_result,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [31:0]          out_value
);

  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [RS_SIZE-1:0]   q1b_q, q1b_d;
  logic [RS_SIZE-1:0]   q2b_q, q2b_d;
  logic [5:0]           op_q   [RS_SIZE];
  logic [5:0]           op_d   [RS_SIZE];
  logic [31:0]          v1_q   [RS_SIZE];
  logic [31:0]          v1_d   [RS_SIZE];
  logic [31:0]          v2_q   [RS_SIZE];
  logic [31:0]          v2_d   [RS_SIZE];
  logic [TAG_WIDTH-1:0] q1_q   [RS_SIZE];
  logic [TAG_WIDTH-1:0] q1_d   [RS_SIZE];
  logic [TAG_WIDTH-1:0] q2_q   [RS_SIZE];
  logic [TAG_WIDTH-1:0] q2_d   [RS_SIZE];
  logic [TAG_WIDTH-1:0] dest_q [RS_SIZE];
  logic [TAG_WIDTH-1:0] dest_d [RS_SIZE];

  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic [31:0]          out_value_q, out_value_d;

  logic [RS_SIZE-1:0] rdy;
  logic [RS_SIZE-1:0] free_vec;
  logic               sel_vld;
  logic [IW-1:0]      sel_idx;
  logic               ins_vld;
  logic [IW-1:0]      ins_idx;
  logic               accept;
  logic               dsp;
  logic               fw1;
  logic               fw2;

  assign rdy     = busy_q & ~q1b_q & ~q2b_q;
  assign rs_full = &busy_q;
  assign accept  = issue_valid & ~rs_full & ~flush & ins_vld;
  assign dsp     = sel_vld & ~flush;

  // Downward scan so the lowest index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // The entry dispatched at this edge may take the new issue.
  always_comb begin
    free_vec = ~busy_q;
    if (sel_vld) free_vec[sel_idx] = 1'b1;
    ins_vld = 1'b0;
    ins_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        ins_vld = 1'b1;
        ins_idx = IW'(i);
      end
    end
  end

  always_comb begin
    alu_openum  = '0;
    alu_oprand1 = '0;
    alu_oprand2 = '0;
    if (sel_vld) begin
      alu_openum  = op_q[sel_idx];
      alu_oprand1 = v1_q[sel_idx];
      alu_oprand2 = v2_q[sel_idx];
    end
  end

  assign fw1 = issue_q1_busy & cdb_valid & (issue_q1 == cdb_tag);
  assign fw2 = issue_q2_busy & cdb_valid & (issue_q2 == cdb_tag);

  always_comb begin
    busy_d = busy_q;
    q1b_d  = q1b_q;
    q2b_d  = q2b_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      op_d[i]   = op_q[i];
      v1_d[i]   = v1_q[i];
      v2_d[i]   = v2_q[i];
      q1_d[i]   = q1_q[i];
      q2_d[i]   = q2_q[i];
      dest_d[i] = dest_q[i];
      if (busy_q[i] && cdb_valid) begin
        if (q1b_q[i] && q1_q[i] == cdb_tag) begin
          v1_d[i]  = cdb_value;
          q1b_d[i] = 1'b0;
        end
        if (q2b_q[i] && q2_q[i] == cdb_tag) begin
          v2_d[i]  = cdb_value;
          q2b_d[i] = 1'b0;
        end
      end
    end
    if (sel_vld) busy_d[sel_idx] = 1'b0;
    if (accept) begin
      busy_d[ins_idx] = 1'b1;
      op_d[ins_idx]   = issue_openum;
      v1_d[ins_idx]   = fw1 ? cdb_value : issue_v1;
      v2_d[ins_idx]   = fw2 ? cdb_value : issue_v2;
      q1b_d[ins_idx]  = issue_q1_busy & ~fw1;
      q2b_d[ins_idx]  = issue_q2_busy & ~fw2;
      q1_d[ins_idx]   = issue_q1;
      q2_d[ins_idx]   = issue_q2;
      dest_d[ins_idx] = issue_dest;
    end
    if (flush) busy_d = '0;
  end

  always_comb begin
    out_valid_d = dsp;
    out_tag_d   = out_tag_q;
    out_value_d = out_value_q;
    if (dsp) begin
      out_tag_d   = dest_q[sel_idx];
      out_value_d = alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      q1b_q       <= '0;
      q2b_q       <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      q1b_q       <= q1b_d;
      q2b_q       <= q2b_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_value_q <= out_value_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= op_d[i];
        v1_q[i]   <= v1_d[i];
        v2_q[i]   <= v2_d[i];
        q1_q[i]   <= q1_d[i];
        q2_q[i]   <= q2_d[i];
        dest_q[i] <= dest_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios then random traffic,
// all outputs compared each cycle against an entry-list reference model.
module tb_alu_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [5:0]  issue_openum;
  logic [31:0] issue_v1, issue_v2;
  logic        issue_q1_busy, issue_q2_busy;
  logic [3:0]  issue_q1, issue_q2, issue_dest;
  logic        rs_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [5:0]  alu_openum;
  logic [31:0] alu_oprand1, alu_oprand2, alu_result;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_value;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] exec(input logic [5:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = exec(alu_openum, alu_oprand1, alu_oprand2);

  alu_rs_scheduler #(.RS_SIZE(8), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_openum(issue_openum),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
    .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_dest(issue_dest),
    .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_openum(alu_openum), .alu_oprand1(alu_oprand1),
    .alu_oprand2(alu_oprand2), .alu_result(alu_result),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] a, b;
    bit        wa, wb;
    bit [3:0]  ta, tb;
    bit [3:0]  dest;
  } ent_t;

  ent_t      m [8];
  bit        m_ov;
  bit [3:0]  m_ot;
  bit [31:0] m_oval;

  function automatic int m_sel();
    for (int i = 0; i < 8; i++)
      if (m[i].busy && !m[i].wa && !m[i].wb) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 8; i++)
      if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m[i] = '{default: 0};
    m_ov = 0; m_ot = 0; m_oval = 0;
  endtask

  task automatic model_step();
    int  s;
    bit  full;
    ent_t e;
    if (flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      m_ov = 0;
      return;
    end
    s = m_sel();
    full = m_full();
    m_ov = (s >= 0);
    if (s >= 0) begin
      m_ot = m[s].dest;
      m_oval = exec(m[s].op, m[s].a, m[s].b);
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i].busy && cdb_valid) begin
        if (m[i].wa && m[i].ta == cdb_tag) begin m[i].a = cdb_value; m[i].wa = 0; end
        if (m[i].wb && m[i].tb == cdb_tag) begin m[i].b = cdb_value; m[i].wb = 0; end
      end
    end
    if (s >= 0) m[s].busy = 0;
    if (issue_valid && !full) begin
      e.busy = 1; e.op = issue_openum; e.dest = issue_dest;
      e.ta = issue_q1; e.tb = issue_q2;
      e.wa = issue_q1_busy; e.wb = issue_q2_busy;
      e.a = issue_v1; e.b = issue_v2;
      if (e.wa && cdb_valid && e.ta == cdb_tag) begin e.a = cdb_value; e.wa = 0; end
      if (e.wb && cdb_valid && e.tb == cdb_tag) begin e.b = cdb_value; e.wb = 0; end
      for (int i = 0; i < 8; i++)
        if (!m[i].busy) begin m[i] = e; break; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    int s;
    s = m_sel();
    chk("rs_full", 32'(rs_full), 32'(m_full()));
    chk("alu_openum", 32'(alu_openum), s >= 0 ? 32'(m[s].op) : 32'd0);
    chk("alu_oprand1", alu_oprand1, s >= 0 ? m[s].a : 32'd0);
    chk("alu_oprand2", alu_oprand2, s >= 0 ? m[s].b : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_tag", 32'(out_tag), 32'(m_ot));
      chk("out_value", out_value, m_oval);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_openum = 0;
    issue_v1 = 0; issue_v2 = 0;
    issue_q1_busy = 0; issue_q2_busy = 0;
    issue_q1 = 0; issue_q2 = 0; issue_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
  endtask

  task automatic iss(input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic wa, input logic [3:0] ta,
                     input logic wb, input logic [3:0] tb, input logic [3:0] d);
    issue_valid = 1; issue_openum = op; issue_v1 = a; issue_v2 = b;
    issue_q1_busy = wa; issue_q1 = ta;
    issue_q2_busy = wb; issue_q2 = tb; issue_dest = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rs_full", 32'(rs_full), 0);
    chk("rst_alu_op1", alu_oprand1, 0);
    @(negedge clk);
    rst_n = 1;

    // both operands ready: out two edges after issue
    iss(6'd22, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0, 4'd3);
    tick();
    idle();
    chk("t1_no_out_yet", 32'(out_valid), 0);
    tick();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_tag", 32'(out_tag), 3);
    chk("t1_value", out_value, 32'hFFFFFFFE);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 0);

    // blocked op woken by CDB
    iss(6'd0, 32'd0, 32'd10, 1, 4'd2, 0, 0, 4'd5);
    tick();
    idle();
    tick();
    chk("t2_blocked", 32'(out_valid), 0);
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'd7;
    tick();
    idle();
    chk("t2_op1", alu_oprand1, 32'd7);
    tick();
    chk("t2_tag", 32'(out_tag), 5);
    chk("t2_value", out_value, 32'd17);

    // issue-time forwarding
    iss(6'd1, 32'd3, 32'd0, 0, 0, 1, 4'd4, 4'd6);
    cdb_valid = 1; cdb_tag = 4'd4; cdb_value = 32'd9;
    tick();
    idle();
    chk("t3_op2_fwd", alu_oprand2, 32'd9);
    tick();
    chk("t3_tag", 32'(out_tag), 6);
    chk("t3_value", out_value, 32'hFFFFFFFA);

    // fill all entries, reject a ninth, free slot 6 and reuse it
    for (int i = 0; i < 8; i++) begin
      iss(6'(i), 32'd0, 32'(i), 1, 4'(i + 8), 0, 0, 4'(i));
      tick();
    end
    chk("t4_full", 32'(rs_full), 1);
    iss(6'd0, 32'd0, 32'd0, 1, 4'd0, 0, 0, 4'd9);
    tick();
    idle();
    chk("t4_still_full", 32'(rs_full), 1);
    cdb_valid = 1; cdb_tag = 4'd14; cdb_value = 32'd100;
    tick();
    idle();
    chk("t4_sel6", alu_oprand1, 32'd100);
    tick();
    chk("t4_out6", 32'(out_tag), 6);
    chk("t4_not_full", 32'(rs_full), 0);
    iss(6'd0, 32'd5, 32'd6, 0, 0, 0, 0, 4'd12);
    tick();
    idle();
    chk("t4_slot6_sel", alu_oprand1, 32'd5);
    tick();
    chk("t4_out12", 32'(out_tag), 12);
    chk("t4_val12", out_value, 32'd11);
    flush = 1;
    tick();
    idle();

    // ready at index 1 and 4 -> back-to-back dispatch
    for (int i = 0; i < 5; i++) begin
      iss(6'd0, 32'd0, 32'd1, 1, (i == 1 || i == 4) ? 4'd2 : 4'd1,
          0, 0, 4'(i));
      tick();
    end
    idle();
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'd50;
    tick();
    idle();
    chk("t5_sel1", alu_oprand1, 32'd50);
    tick();
    chk("t5_first", 32'(out_tag), 1);
    tick();
    chk("t5_second_v", 32'(out_valid), 1);
    chk("t5_second", 32'(out_tag), 4);
    tick();
    chk("t5_done", 32'(out_valid), 0);

    // flush beats a pending issue
    flush = 1;
    iss(6'd0, 32'd1, 32'd1, 0, 0, 0, 0, 4'd7);
    tick();
    idle();
    chk("t6_empty", 32'(rs_full), 0);
    chk("t6_no_out", 32'(out_valid), 0);
    chk("t6_no_sel", 32'(alu_openum), 0);
    cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'd1;
    tick();
    idle();
    tick();
    chk("t6_gone", 32'(out_valid), 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(2) != 0)
        iss(6'($urandom), $urandom, $urandom,
            1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
            4'($urandom));
      cdb_valid = 1'($urandom);
      cdb_tag = 4'($urandom);
      cdb_value = $urandom;
      flush = ($urandom_range(39) == 0);
      tick();
    end

    // async reset mid-cycle with live state
    idle();
    iss(6'd2, 32'd9, 32'd9, 0, 0, 0, 0, 4'd8);
    tick();
    idle();
    #2;
    rst_n = 0;
    #1;
    m_reset();
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_tag", 32'(out_tag), 0);
    chk("rst_mid_value", out_value, 0);
    chk("rst_mid_full", 32'(rs_full), 0);
    chk("rst_mid_op", 32'(alu_openum), 0);
    chk("rst_mid_a", alu_oprand1, 0);
    chk("rst_mid_b", alu_oprand2, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
